// File: rtl/bsg_mem_2r1w_sync_sched.sv
// Scheduler in front of a 2R1W synchronous-read RAM. It clears the RAM after reset,
// shares the two read ports round-robin among requesters and tags each response by requester.
module bsg_mem_2r1w_sync_sched #(
  parameter int unsigned width_p                = 32,
  parameter int unsigned els_p                  = 64,
  parameter int unsigned num_req_p              = 4,
  parameter bit          read_write_same_addr_p = 1'b0,
  localparam int unsigned addr_width_lp         = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  output logic                               init_done_o,
  input  logic                               w_v_i,
  input  logic [addr_width_lp-1:0]           w_addr_i,
  input  logic [width_p-1:0]                 w_data_i,
  output logic                               w_ready_o,
  input  logic [num_req_p-1:0]               r_v_i,
  input  logic [num_req_p*addr_width_lp-1:0] r_addr_i,
  output logic [num_req_p-1:0]               r_ready_o,
  output logic [num_req_p-1:0]               r_v_o,
  output logic [num_req_p*width_p-1:0]       r_data_o,
  output logic                               mem_w_v_o,
  output logic [addr_width_lp-1:0]           mem_w_addr_o,
  output logic [width_p-1:0]                 mem_w_data_o,
  output logic                               mem_r0_v_o,
  output logic [addr_width_lp-1:0]           mem_r0_addr_o,
  output logic                               mem_r1_v_o,
  output logic [addr_width_lp-1:0]           mem_r1_addr_o,
  input  logic [width_p-1:0]                 mem_r0_data_i,
  input  logic [width_p-1:0]                 mem_r1_data_i
);

  localparam int unsigned idx_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                       r_state;
  logic [addr_width_lp-1:0]     r_cnt;
  logic [idx_w_lp-1:0]          r_rr;
  logic                         r_t0_v, r_t1_v;
  logic [idx_w_lp-1:0]          r_t0_idx, r_t1_idx;
  logic [num_req_p*width_p-1:0] r_resp_data;

  logic [num_req_p-1:0] w_elig;
  logic                 w_g0_v, w_g1_v;
  logic [idx_w_lp-1:0]  w_g0_idx, w_g1_idx, w_j, w_rr_d;

  function automatic logic [idx_w_lp-1:0] f_wrap(input int v);
    return idx_w_lp'(v % int'(num_req_p));
  endfunction

  // A read that would hit the address being written this cycle is held off.
  always_comb begin
    w_elig = '0;
    for (int k = 0; k < int'(num_req_p); k++) begin
      w_elig[k] = r_v_i[k] &
                  ~((read_write_same_addr_p == 1'b0) & w_v_i &
                    (r_addr_i[k*addr_width_lp +: addr_width_lp] == w_addr_i));
    end
  end

  always_comb begin
    w_g0_v   = 1'b0;
    w_g1_v   = 1'b0;
    w_g0_idx = '0;
    w_g1_idx = '0;
    w_j      = '0;
    if (r_state == StRun) begin
      for (int i = 0; i < int'(num_req_p); i++) begin
        w_j = f_wrap(int'(r_rr) + i);
        if (w_elig[w_j]) begin
          if (!w_g0_v) begin
            w_g0_v   = 1'b1;
            w_g0_idx = w_j;
          end else if (!w_g1_v) begin
            w_g1_v   = 1'b1;
            w_g1_idx = w_j;
          end
        end
      end
    end
  end

  always_comb begin
    r_ready_o = '0;
    if (w_g0_v) r_ready_o[w_g0_idx] = 1'b1;
    if (w_g1_v) r_ready_o[w_g1_idx] = 1'b1;
    w_rr_d = r_rr;
    if (w_g1_v)      w_rr_d = f_wrap(int'(w_g1_idx) + 1);
    else if (w_g0_v) w_rr_d = f_wrap(int'(w_g0_idx) + 1);
  end

  assign init_done_o   = (r_state == StRun);
  assign w_ready_o     = (r_state == StRun);
  assign mem_w_v_o     = (r_state == StInit) ? 1'b1  : w_v_i;
  assign mem_w_addr_o  = (r_state == StInit) ? r_cnt : w_addr_i;
  assign mem_w_data_o  = (r_state == StInit) ? '0    : w_data_i;
  assign mem_r0_v_o    = w_g0_v;
  assign mem_r1_v_o    = w_g1_v;
  assign mem_r0_addr_o = w_g0_v ? r_addr_i[w_g0_idx*addr_width_lp +: addr_width_lp] : '0;
  assign mem_r1_addr_o = w_g1_v ? r_addr_i[w_g1_idx*addr_width_lp +: addr_width_lp] : '0;

  // Responding slices take RAM data straight through; idle slices replay their last value.
  always_comb begin
    r_v_o    = '0;
    r_data_o = r_resp_data;
    if (r_t0_v) begin
      r_v_o[r_t0_idx] = 1'b1;
      r_data_o[r_t0_idx*width_p +: width_p] = mem_r0_data_i;
    end
    if (r_t1_v) begin
      r_v_o[r_t1_idx] = 1'b1;
      r_data_o[r_t1_idx*width_p +: width_p] = mem_r1_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= StInit;
      r_cnt       <= '0;
      r_rr        <= '0;
      r_t0_v      <= 1'b0;
      r_t1_v      <= 1'b0;
      r_t0_idx    <= '0;
      r_t1_idx    <= '0;
      r_resp_data <= '0;
    end else begin
      unique case (r_state)
        StInit: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == addr_width_lp'(els_p - 1)) r_state <= StRun;
        end
        StRun:   r_state <= StRun;
        default: r_state <= StInit;
      endcase
      r_rr        <= w_rr_d;
      r_t0_v      <= w_g0_v;
      r_t1_v      <= w_g1_v;
      r_t0_idx    <= w_g0_idx;
      r_t1_idx    <= w_g1_idx;
      r_resp_data <= r_data_o;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!w_v_i || (32'(w_addr_i) < els_p));
      for (int k = 0; k < int'(num_req_p); k++) begin
        assert (!r_v_i[k] || (32'(r_addr_i[k*addr_width_lp +: addr_width_lp]) < els_p));
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mem_2r1w_sync_sched.sv
// Directed bench for bsg_mem_2r1w_sync_sched: RAM clear, arbitration, collisions, resets.
module tb_bsg_mem_2r1w_sync_sched;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         init_done;
  logic         w_v;
  logic [5:0]   w_addr;
  logic [31:0]  w_data;
  logic         w_ready;
  logic [3:0]   r_v;
  logic [23:0]  r_addr;
  logic [3:0]   r_ready;
  logic [3:0]   r_v_out;
  logic [127:0] r_data;
  logic         mw_v, m0_v, m1_v;
  logic [5:0]   mw_addr, m0_addr, m1_addr;
  logic [31:0]  mw_data, m0_data, m1_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bsg_mem_2r1w_sync_sched dut (
    .clk_i(clk), .reset_n_i(reset_n), .init_done_o(init_done),
    .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data), .w_ready_o(w_ready),
    .r_v_i(r_v), .r_addr_i(r_addr), .r_ready_o(r_ready), .r_v_o(r_v_out), .r_data_o(r_data),
    .mem_w_v_o(mw_v), .mem_w_addr_o(mw_addr), .mem_w_data_o(mw_data),
    .mem_r0_v_o(m0_v), .mem_r0_addr_o(m0_addr), .mem_r1_v_o(m1_v), .mem_r1_addr_o(m1_addr),
    .mem_r0_data_i(m0_data), .mem_r1_data_i(m1_data)
  );

  // RAM model; starts with junk so the clear is observable.
  logic [31:0] ram [64];
  initial for (int i = 0; i < 64; i++) ram[i] = 32'hBAD0_0000 + i;
  always @(posedge clk) begin
    if (mw_v) ram[mw_addr] <= mw_data;
    if (m0_v) m0_data <= ram[m0_addr];
    if (m1_v) m1_data <= ram[m1_addr];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] rv; logic [5:0] a0, a1, a2, a3; logic wv; logic [5:0] wa; logic [31:0] wd;
    logic [3:0] e_rdy; logic e_p0v; logic [5:0] e_p0a; logic e_p1v; logic [5:0] e_p1a;
    logic [3:0] e_rv; logic [31:0] e_d0, e_d1, e_d2, e_d3;
  } vec_t;

  vec_t tbl [20];

  initial begin
    int bad;
    logic [31:0] ed [4];

    tbl[0]  = '{4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 6'd10, 32'h1010,
                4'b0000, 1'b0, 6'd0, 1'b0, 6'd0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[1]  = '{4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 6'd11, 32'h1111,
                4'b0000, 1'b0, 6'd0, 1'b0, 6'd0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[2]  = '{4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 6'd12, 32'h1212,
                4'b0000, 1'b0, 6'd0, 1'b0, 6'd0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[3]  = '{4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 6'd13, 32'h1313,
                4'b0000, 1'b0, 6'd0, 1'b0, 6'd0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[4]  = '{4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 6'd9, 32'h0909,
                4'b0000, 1'b0, 6'd0, 1'b0, 6'd0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[5]  = '{4'b0100, 6'd0, 6'd0, 6'd5, 6'd0, 1'b0, 6'd0, 32'h0,
                4'b0100, 1'b1, 6'd5, 1'b0, 6'd0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[6]  = '{4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 6'd5, 32'hDEADBEEF,
                4'b0000, 1'b0, 6'd0, 1'b0, 6'd0, 4'b0100, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[7]  = '{4'b0100, 6'd0, 6'd0, 6'd5, 6'd0, 1'b0, 6'd0, 32'h0,
                4'b0100, 1'b1, 6'd5, 1'b0, 6'd0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[8]  = '{4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0,
                4'b0000, 1'b0, 6'd0, 1'b0, 6'd0, 4'b0100, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    tbl[9]  = '{4'b1000, 6'd0, 6'd0, 6'd0, 6'd7, 1'b0, 6'd0, 32'h0,
                4'b1000, 1'b1, 6'd7, 1'b0, 6'd0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[10] = '{4'b1000, 6'd0, 6'd0, 6'd0, 6'd7, 1'b0, 6'd0, 32'h0,
                4'b1000, 1'b1, 6'd7, 1'b0, 6'd0, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[11] = '{4'b1111, 6'd10, 6'd11, 6'd12, 6'd13, 1'b0, 6'd0, 32'h0,
                4'b0011, 1'b1, 6'd10, 1'b1, 6'd11, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[12] = '{4'b1111, 6'd10, 6'd11, 6'd12, 6'd13, 1'b0, 6'd0, 32'h0,
                4'b1100, 1'b1, 6'd12, 1'b1, 6'd13, 4'b0011, 32'h1010, 32'h1111, 32'h0, 32'h0};
    tbl[13] = '{4'b1111, 6'd10, 6'd11, 6'd12, 6'd13, 1'b0, 6'd0, 32'h0,
                4'b0011, 1'b1, 6'd10, 1'b1, 6'd11, 4'b1100, 32'h0, 32'h0, 32'h1212, 32'h1313};
    tbl[14] = '{4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0,
                4'b0000, 1'b0, 6'd0, 1'b0, 6'd0, 4'b0011, 32'h1010, 32'h1111, 32'h0, 32'h0};
    tbl[15] = '{4'b0111, 6'd10, 6'd9, 6'd12, 6'd0, 1'b1, 6'd9, 32'hCAFEF00D,
                4'b0101, 1'b1, 6'd12, 1'b1, 6'd10, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[16] = '{4'b0010, 6'd0, 6'd9, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0,
                4'b0010, 1'b1, 6'd9, 1'b0, 6'd0, 4'b0101, 32'h1010, 32'h0, 32'h1212, 32'h0};
    tbl[17] = '{4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0,
                4'b0000, 1'b0, 6'd0, 1'b0, 6'd0, 4'b0010, 32'h0, 32'hCAFEF00D, 32'h0, 32'h0};
    tbl[18] = '{4'b0011, 6'd5, 6'd5, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0,
                4'b0011, 1'b1, 6'd5, 1'b1, 6'd5, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[19] = '{4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0,
                4'b0000, 1'b0, 6'd0, 1'b0, 6'd0, 4'b0011, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0};

    // Reset with every requester and the writer pushing.
    reset_n = 1'b1;
    r_v = 4'hF; r_addr = '0; w_v = 1'b1; w_addr = 6'd3; w_data = 32'h55;
    #2 reset_n = 1'b0;
    #1;
    chk("reset init_done", 128'(init_done), 128'(0));
    chk("reset r_v_o", 128'(r_v_out), 128'(0));
    chk("reset r_ready", 128'(r_ready), 128'(0));
    chk("reset w_ready", 128'(w_ready), 128'(0));
    chk("reset mem_w_addr", 128'(mw_addr), 128'(0));
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (!mw_v || mw_addr != 6'(i) || mw_data != 32'h0 || init_done || w_ready ||
          r_ready != 4'h0 || m0_v || m1_v || r_v_out != 4'h0) bad++;
      @(negedge clk);
    end
    chk("init clear sequence bad cycles", 128'(bad), 128'(0));
    r_v = 4'h0; w_v = 1'b0;
    #1;
    chk("init_done after 64", 128'(init_done), 128'(1));
    chk("w_ready in run", 128'(w_ready), 128'(1));
    for (int i = 0; i < 64; i++) chk($sformatf("ram cleared %0d", i), 128'(ram[i]), 128'(0));

    foreach (tbl[i]) begin
      r_v = tbl[i].rv; r_addr = {tbl[i].a3, tbl[i].a2, tbl[i].a1, tbl[i].a0};
      w_v = tbl[i].wv; w_addr = tbl[i].wa; w_data = tbl[i].wd;
      #1;
      chk($sformatf("v%0d r_ready", i), 128'(r_ready), 128'(tbl[i].e_rdy));
      chk($sformatf("v%0d r_v_o", i), 128'(r_v_out), 128'(tbl[i].e_rv));
      chk($sformatf("v%0d mem_r0_v", i), 128'(m0_v), 128'(tbl[i].e_p0v));
      chk($sformatf("v%0d mem_r1_v", i), 128'(m1_v), 128'(tbl[i].e_p1v));
      if (tbl[i].e_p0v) chk($sformatf("v%0d mem_r0_addr", i), 128'(m0_addr), 128'(tbl[i].e_p0a));
      if (tbl[i].e_p1v) chk($sformatf("v%0d mem_r1_addr", i), 128'(m1_addr), 128'(tbl[i].e_p1a));
      chk($sformatf("v%0d mem_w_v", i), 128'(mw_v), 128'(tbl[i].wv));
      ed[0] = tbl[i].e_d0; ed[1] = tbl[i].e_d1; ed[2] = tbl[i].e_d2; ed[3] = tbl[i].e_d3;
      for (int k = 0; k < 4; k++)
        if (tbl[i].e_rv[k])
          chk($sformatf("v%0d data%0d", i, k), 128'(r_data[k*32 +: 32]), 128'(ed[k]));
      @(negedge clk);
    end

    // Reset during RUN with a response pending.
    r_v = 4'b0001; r_addr = {6'd0, 6'd0, 6'd0, 6'd5}; w_v = 1'b0;
    #1 chk("pend r_ready", 128'(r_ready), 128'(4'b0001));
    @(negedge clk);
    r_v = 4'h0;
    #1 chk("pend r_v_o before reset", 128'(r_v_out), 128'(4'b0001));
    reset_n = 1'b0;
    #1;
    chk("run reset r_v_o", 128'(r_v_out), 128'(0));
    chk("run reset init_done", 128'(init_done), 128'(0));
    chk("run reset mem_w_addr", 128'(mw_addr), 128'(0));
    chk("run reset w_ready", 128'(w_ready), 128'(0));
    bad = 0;
    @(negedge clk); if (r_v_out != 4'h0) bad++;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r_v_out != 4'h0) bad++;
    end
    #1 chk("init counter at 20", 128'(mw_addr), 128'(20));

    // Reset during INIT restarts the clear from address 0.
    reset_n = 1'b0;
    #1;
    chk("init reset mem_w_addr", 128'(mw_addr), 128'(0));
    chk("init reset init_done", 128'(init_done), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (r_v_out != 4'h0) bad++;
      if (mw_addr != 6'(i)) bad++;
      @(negedge clk);
    end
    chk("reclear addrs and no r_v_o pulse", 128'(bad), 128'(0));
    #1 chk("init_done after re-clear", 128'(init_done), 128'(1));

    // rr restarts at 0; lone req 3 takes port 0 and sees cleared data.
    r_v = 4'b1000; r_addr = {6'd9, 6'd0, 6'd0, 6'd0};
    #1;
    chk("post reset r_ready", 128'(r_ready), 128'(4'b1000));
    chk("post reset mem_r0_addr", 128'(m0_addr), 128'(9));
    @(negedge clk);
    r_v = 4'h0;
    #1;
    chk("post reset r_v_o", 128'(r_v_out), 128'(4'b1000));
    chk("post reset data3", 128'(r_data[96 +: 32]), 128'(0));
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bsg_mem_2r1w_sync_sched.md
Name: bsg_mem_2r1w_sync_sched

Overview:
Front-end scheduler for a 2-read/1-write synchronous-read RAM. It clears the RAM after reset, then shares the two read ports among num_req_p read requesters using round-robin. It admits one writer per cycle and returns read data, tagged per requester, one cycle after grant. It sits between cache/regfile-style clients and the RAM instance, and drives all of the RAM's ports.

Parameters:
width_p, 32, data width of the RAM
els_p, 64, number of RAM entries
num_req_p, 4, number of read requesters (>=2)
read_write_same_addr_p, 0, 1 = RAM returns new data on same-address read/write; 0 = scheduler must prevent that collision
addr_width_lp, `BSG_SAFE_CLOG2(els_p), address width (derived)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset; asynchronous, active-low
init_done_o  out  1  high once RAM clear is complete
w_v_i  in  1  write request
w_addr_i  in  addr_width_lp  write address
w_data_i  in  width_p  write data
w_ready_o  out  1  write accepted when w_v_i & w_ready_o
r_v_i  in  num_req_p  per-requester read request
r_addr_i  in  num_req_p*addr_width_lp  per-requester read address, packed, requester 0 in LSBs
r_ready_o  out  num_req_p  per-requester grant; a read is accepted when r_v_i[k] & r_ready_o[k]
r_v_o  out  num_req_p  response valid, one cycle after accept
r_data_o  out  num_req_p*width_p  response data, packed
mem_w_v_o, mem_w_addr_o, mem_w_data_o  out  1/addr_width_lp/width_p  RAM write port
mem_r0_v_o, mem_r0_addr_o  out  1/addr_width_lp  RAM read port 0
mem_r1_v_o, mem_r1_addr_o  out  1/addr_width_lp  RAM read port 1
mem_r0_data_i, mem_r1_data_i  in  width_p  RAM read data, valid the cycle after the port's valid

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk deassert assumed upstream): state=INIT, init counter=0, rr pointer=0, r_v_o=0, init_done_o=0, tag registers cleared.
- Reset asserted mid-operation behaves identically; any in-flight responses are dropped.
- FSM INIT:
  - mem_w_v_o=1, mem_w_addr_o=counter, mem_w_data_o=0.
  - w_ready_o=0, r_ready_o=0, both mem read valids=0.
  - Counter increments each cycle. When counter==els_p-1 the write still occurs, and the next state is RUN.
  - Clear takes exactly els_p cycles.
- FSM RUN: init_done_o=1. RUN is terminal until reset.
- Write in RUN:
  - w_ready_o=1 always.
  - mem_w_* = w_* directly (combinational); write has priority over reads.
- Read eligibility: requester k is eligible if r_v_i[k] and NOT (read_write_same_addr_p==0 & w_v_i & r_addr[k]==w_addr_i).
- Read arbitration:
  - Scan eligible requesters in order rr, rr+1, ... mod num_req_p.
  - First found -> port 0; second found -> port 1. At most 2 grants per cycle.
  - r_ready_o is the one-hot-per-port grant vector. r_ready_o depends on r_v_i (valid-then-ready).
- Pointer update:
  - 2 grants: rr <= (index of the port-1 grant)+1 mod num_req_p.
  - 1 grant: rr <= (index of that grant)+1.
  - 0 grants: rr unchanged.
- Response path:
  - Registered tag per port (valid + requester index).
  - Next cycle, r_v_o[idx]=1 and r_data_o slice idx = that port's mem data.
  - Other slices hold their last value; r_data_o is only meaningful when r_v_o is set.
  - Responses have no backpressure; latency is exactly 1.
- Same-address reads by two requesters are both granted; each gets the same data.
- Blocked requester: stays unready while its address collides with an active write. Since it is skipped by the scan, it is retried next cycle without losing its rr position.
- Synthesis-hidden assertions: w_addr_i < els_p and each r_addr < els_p whenever the corresponding valid is high.

Test Plan:
- Reset then idle, els_p=64 -> exactly 64 writes of 0 to addresses 0..63; init_done_o rises on cycle 65; no r_ready_o during INIT.
- Post-init read of addr 5 by req 2 -> r_ready_o=4'b0100; next cycle r_v_o=4'b0100 with data 0. Write 0xDEADBEEF to 5, then read -> 0xDEADBEEF.
- All 4 requesters valid every cycle, distinct addresses -> grants {0,1},{2,3},{0,1}...; each requester is served every 2 cycles.
- read_write_same_addr_p=0, write addr 9 and req 1 reads 9 in the same cycle -> req 1 not granted, req 0 and req 2 granted. Next cycle with no write, req 1 is granted and returns the new data.
- Only req 3 valid, rr=0 -> req 3 granted on port 0; rr becomes 0 (wrap).
- Assert reset_n_i low during INIT at counter=20 and during RUN with a response pending -> outputs clear immediately (async); INIT restarts from address 0; no r_v_o pulse emitted.
